dsp_mac_sequencer: RTL and testbench

- Controller that sequences the DSP48A1 slice (pre-adder bypassed) through an N-term multiply-accumulate, P = sum of A[k]*B[k] for k = 0..N-1.
- Accepts operand pairs over a valid/ready handshake and drives the slice's clock enables and OPMODE, aligned to the slice's pipeline-register configuration.
- Sits between the operand source and the slice.
- Flags the cycle on which the slice P output holds the final sum.

---
 rtl/dsp_mac_sequencer_if.sv | 29 ++
 rtl/dsp_mac_sequencer.sv | 153 +++++++++++++++
 tb/tb_dsp_mac_sequencer.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dsp_mac_sequencer_if.sv
// Operand-source handshake and DSP48A1 slice control bundle for the MAC sequencer.
interface dsp_mac_sequencer_if #(
   parameter int unsigned CNT_W = 10
);
   logic             start;
   logic [CNT_W-1:0] len;
   logic             in_valid;
   logic             in_ready;
   logic             cea;
   logic             ceb;
   logic             cem;
   logic             cep;
   logic [7:0]       opmode;
   logic             busy;
   logic             res_valid;
   logic             done;

   // Sequencer side: consumes run requests/operands, drives slice controls.
   modport master (
      input  start, len, in_valid,
      output in_ready, cea, ceb, cem, cep, opmode, busy, res_valid, done
   );

   // Source/observer side.
   modport slave (
      output start, len, in_valid,
      input  in_ready, cea, ceb, cem, cep, opmode, busy, res_valid, done
   );
endinterface

// File: rtl/dsp_mac_sequencer.sv
// Sequences a DSP48A1 slice (pre-adder bypassed) through an N-term multiply-accumulate.
// A {valid, first} flag pipeline matched to the slice's A/B and M register depth
// decides, at the post-adder stage, whether P loads, accumulates or holds.
module dsp_mac_sequencer #(
   parameter int unsigned CNT_W  = 10,
   parameter int unsigned IN_LAT = 1,
   parameter int unsigned M_LAT  = 1
) (
   input  logic                clk,
   input  logic                rst,
   dsp_mac_sequencer_if.master bus
);

   localparam int unsigned LAT     = IN_LAT + M_LAT;
   localparam logic [7:0]  OP_LOAD = 8'h01;  // X=M, Z=0
   localparam logic [7:0]  OP_ACC  = 8'h09;  // X=M, Z=P
   localparam logic [7:0]  OP_HOLD = 8'h00;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DRAIN = 2'd2,
      FIN   = 2'd3
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [CNT_W-1:0] remaining;
   logic [CNT_W-1:0] len_q;
   logic             in_ready;
   logic             accept;
   logic             first_beat;
   logic             last_beat;
   logic             post_valid;
   logic             post_first;
   logic             inner_valid;
   logic             ce_q;
   logic             busy_q;
   logic             done_q;
   logic             res_valid_q;

   assign in_ready   = (state == ACCUM) && (remaining != '0);
   assign accept     = bus.in_valid && in_ready;
   assign first_beat = (remaining == len_q);
   assign last_beat  = (remaining == CNT_W'(1));

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state decode; DRAIN exits once only the post-adder stage may still hold a beat.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (bus.start) begin
               state_next = (bus.len == '0) ? FIN : ACCUM;
            end
         end
         ACCUM: begin
            if (accept && last_beat) begin
               state_next = (LAT == 0) ? FIN : DRAIN;
            end
         end
         DRAIN: begin
            if (!inner_valid) begin
               state_next = FIN;
            end
         end
         FIN:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Term counter: loaded on start, decremented per accepted beat.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         remaining <= '0;
         len_q     <= '0;
      end else if ((state == IDLE) && bus.start) begin
         remaining <= bus.len;
         len_q     <= bus.len;
      end else if (accept) begin
         remaining <= remaining - CNT_W'(1);
      end
   end

   // Registered status and A/B/M enables, decoded from the next state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ce_q        <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         res_valid_q <= 1'b0;
      end else begin
         ce_q        <= (state_next == ACCUM) || (state_next == DRAIN);
         busy_q      <= (state_next != IDLE);
         done_q      <= (state_next == FIN);
         res_valid_q <= (state_next == FIN) && (state != IDLE);
      end
   end

   generate
      if (LAT == 0) begin : g_direct
         assign post_valid  = accept;
         assign post_first  = accept && first_beat;
         assign inner_valid = 1'b0;
      end else begin : g_pipe
         logic [LAT-1:0] flag_valid;
         logic [LAT-1:0] flag_first;

         // Flag shift register; stage LAT-1 lines up with the post-adder.
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               flag_valid <= '0;
               flag_first <= '0;
            end else begin
               flag_valid[0] <= accept;
               flag_first[0] <= accept && first_beat;
               for (int unsigned i = 1; i < LAT; i++) begin
                  flag_valid[i] <= flag_valid[i-1];
                  flag_first[i] <= flag_first[i-1];
               end
            end
         end

         assign post_valid = flag_valid[LAT-1];
         assign post_first = flag_first[LAT-1];

         if (LAT > 1) begin : g_inner
            assign inner_valid = |flag_valid[LAT-2:0];
         end else begin : g_single
            assign inner_valid = 1'b0;
         end
      end
   endgenerate

   assign bus.in_ready  = in_ready;
   assign bus.cea       = ce_q;
   assign bus.ceb       = ce_q;
   assign bus.cem       = ce_q;
   assign bus.cep       = post_valid;
   assign bus.opmode    = post_valid ? (post_first ? OP_LOAD : OP_ACC) : OP_HOLD;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.res_valid = res_valid_q;

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Bench for dsp_mac_sequencer (IN_LAT=1, M_LAT=1) with a behavioural DSP48A1 slice model.
module tb_dsp_mac_sequencer;

   localparam int unsigned CNT_W = 10;
   localparam int          NCYC  = 20;

   typedef struct {
      int          n;
      logic [31:0] bub;
      int          off;
      int          exp_done;
      logic [31:0] exp_rdy;
      logic [31:0] exp_cep;
   } vec_t;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   dsp_mac_sequencer_if #(.CNT_W(CNT_W)) bus ();

   dsp_mac_sequencer #(
      .CNT_W (CNT_W),
      .IN_LAT(1),
      .M_LAT (1)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   // Slice model: A/B register, M register, P post-adder.
   logic [17:0] a_in, b_in, a_r, b_r;
   logic [35:0] m_r;
   logic [47:0] p_r;

   always_ff @(posedge clk) begin
      if (bus.cea) a_r <= a_in;
      if (bus.ceb) b_r <= b_in;
      if (bus.cem) m_r <= 36'(a_r) * 36'(b_r);
      if (bus.cep) begin
         case (bus.opmode)
            8'h01:   p_r <= 48'(m_r);
            8'h09:   p_r <= p_r + 48'(m_r);
            default: p_r <= p_r;
         endcase
      end
   end

   int          checks   = 0;
   int          failures = 0;
   logic [47:0] sb [$];
   int          cur_n, beat_idx, off, n_acc;
   logic [31:0] tr_rdy, tr_cep, tr_cea, tr_ceb, tr_cem, tr_busy, tr_done, tr_rv;
   logic [7:0]  tr_op [32];
   vec_t        vecs [6];
   vec_t        rec;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   function automatic logic [47:0] exp_sum(input int n, input int o);
      longint s = 0;
      for (int k = 0; k < n; k++) s += longint'(k + 1 + o) * longint'(k + 1);
      return 48'(s);
   endfunction

   task automatic clear_traces();
      tr_rdy = '0; tr_cep = '0; tr_cea = '0; tr_ceb = '0; tr_cem = '0;
      tr_busy = '0; tr_done = '0; tr_rv = '0;
      for (int i = 0; i < 32; i++) tr_op[i] = 8'h00;
   endtask

   // One clock cycle: drive after the rising edge, sample on the falling edge.
   task automatic step(input int c, input logic st, input logic [CNT_W-1:0] ln, input logic vld);
      bus.start    = st;
      bus.len      = ln;
      bus.in_valid = vld;
      if (vld) begin
         a_in = 18'(beat_idx + 1 + off);
         b_in = 18'(beat_idx + 1);
      end else begin
         a_in = 18'h2aaaa;
         b_in = 18'h15555;
      end
      @(negedge clk);
      tr_rdy[c]  = bus.in_ready;
      tr_cep[c]  = bus.cep;
      tr_cea[c]  = bus.cea;
      tr_ceb[c]  = bus.ceb;
      tr_cem[c]  = bus.cem;
      tr_busy[c] = bus.busy;
      tr_done[c] = bus.done;
      tr_rv[c]   = bus.res_valid;
      tr_op[c]   = bus.opmode;
      if (bus.in_valid && bus.in_ready) begin
         n_acc++;
         beat_idx = (beat_idx + 1 == cur_n) ? 0 : beat_idx + 1;
      end
      if (bus.res_valid) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_res_valid cycle=%0d p=%0h", c, p_r);
         end else begin
            check("sum", 64'(p_r), 64'(sb.pop_front()));
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, "_in_ready"},  64'(bus.in_ready),  64'(0));
      check({tag, "_cea"},       64'(bus.cea),       64'(0));
      check({tag, "_ceb"},       64'(bus.ceb),       64'(0));
      check({tag, "_cem"},       64'(bus.cem),       64'(0));
      check({tag, "_cep"},       64'(bus.cep),       64'(0));
      check({tag, "_opmode"},    64'(bus.opmode),    64'(0));
      check({tag, "_busy"},      64'(bus.busy),      64'(0));
      check({tag, "_done"},      64'(bus.done),      64'(0));
      check({tag, "_res_valid"}, 64'(bus.res_valid), 64'(0));
   endtask

   task automatic run_case(input vec_t v);
      logic [31:0] ce_exp;
      logic [7:0]  op_exp;
      bit          seen;
      cur_n = v.n; off = v.off; beat_idx = 0; n_acc = 0;
      clear_traces();
      if (v.n > 0) sb.push_back(exp_sum(v.n, v.off));
      for (int c = 0; c < NCYC; c++) step(c, c == 0, CNT_W'(v.n), !v.bub[c]);
      ce_exp = (v.n > 0) ? ((32'd1 << v.exp_done) - 32'd2) : 32'd0;
      check("in_ready_trace",  64'(tr_rdy),  64'(v.exp_rdy));
      check("cep_trace",       64'(tr_cep),  64'(v.exp_cep));
      check("done_trace",      64'(tr_done), 64'(32'd1 << v.exp_done));
      check("res_valid_trace", 64'(tr_rv),   64'((v.n > 0) ? (32'd1 << v.exp_done) : 32'd0));
      check("busy_trace",      64'(tr_busy), 64'((32'd1 << (v.exp_done + 1)) - 32'd2));
      check("cea_trace",       64'(tr_cea),  64'(ce_exp));
      check("ceb_trace",       64'(tr_ceb),  64'(ce_exp));
      check("cem_trace",       64'(tr_cem),  64'(ce_exp));
      check("beats_accepted",  64'(n_acc),   64'(v.n));
      seen = 1'b0;
      for (int c = 0; c < NCYC; c++) begin
         if (v.exp_cep[c]) begin
            op_exp = seen ? 8'h09 : 8'h01;
            seen   = 1'b1;
         end else begin
            op_exp = 8'h00;
         end
         check($sformatf("opmode_c%0d", c), 64'(tr_op[c]), 64'(op_exp));
      end
      check("sb_drained", 64'(sb.size()), 64'(0));
      sb.delete();
   endtask

   initial begin
      // Watchdog so the bench always ends.
      #200000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{4, 32'h0,  0, 7,  32'h1E,  32'h78};
      vecs[1] = '{4, 32'h4,  0, 8,  32'h3E,  32'hE8};
      vecs[2] = '{1, 32'h0,  5, 4,  32'h02,  32'h08};
      vecs[3] = '{0, 32'h0,  0, 1,  32'h00,  32'h00};
      vecs[4] = '{7, 32'h22, 1, 12, 32'h3FE, 32'hF70};
      vecs[5] = '{3, 32'hE,  3, 9,  32'h7E,  32'h1C0};

      rst = 1'b0;
      bus.start = 1'b0; bus.len = '0; bus.in_valid = 1'b0;
      a_in = '0; b_in = '0;
      cur_n = 0; off = 0; beat_idx = 0; n_acc = 0;
      clear_traces();
      repeat (2) @(posedge clk);
      #1;
      check_zero_outputs("reset");
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;

      // Table of single runs.
      for (int i = 0; i < 6; i++) run_case(vecs[i]);

      // Bubble case: P must read A=B=1..4 squared sum.
      check("sum_30_model", 64'(exp_sum(4, 0)), 64'(48'd30));

      // start held high through a run: ignored until IDLE, then a second run.
      cur_n = 4; off = 2; beat_idx = 0; n_acc = 0;
      clear_traces();
      sb.push_back(exp_sum(4, 2));
      sb.push_back(exp_sum(4, 2));
      for (int c = 0; c < NCYC; c++) step(c, c <= 8, CNT_W'(4), 1'b1);
      check("hold_done_trace", 64'(tr_done), 64'((32'd1 << 7) | (32'd1 << 15)));
      check("hold_rdy_trace",  64'(tr_rdy),  64'(32'h1E1E));
      check("hold_cep_trace",  64'(tr_cep),  64'(32'h7878));
      check("hold_busy_trace", 64'(tr_busy), 64'(32'hFEFE));
      check("hold_beats",      64'(n_acc),   64'(8));
      check("hold_sb_drained", 64'(sb.size()), 64'(0));
      sb.delete();

      // Asynchronous reset in cycle 3 of a len=4 run.
      cur_n = 4; off = 0; beat_idx = 0; n_acc = 0;
      clear_traces();
      sb.push_back(exp_sum(4, 0));
      for (int c = 0; c < 3; c++) step(c, c == 0, CNT_W'(4), 1'b1);
      bus.in_valid = 1'b1;
      #2;
      rst = 1'b0;
      #1;
      check_zero_outputs("midrun_reset");
      sb.delete();
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      clear_traces();
      for (int c = 0; c < 6; c++) step(c, 1'b0, CNT_W'(0), 1'b0);
      check("post_reset_done",      64'(tr_done), 64'(0));
      check("post_reset_res_valid", 64'(tr_rv),   64'(0));
      check("post_reset_busy",      64'(tr_busy), 64'(0));

      // Recovery run with len=2.
      rec = '{2, 32'h0, 4, 5, 32'h06, 32'h18};
      run_case(rec);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
